moldudp64_deframer: RTL

Upstream neighbour of the ITCH parser. Consumes the UDP payload of MoldUDP64 downstream packets as 64-bit AXI-Stream beats, strips the 20-byte session header and each 2-byte message-length prefix, and re-emits every ITCH message as its own AXI-Stream frame. Each frame starts with message byte 0 at tdata[63:56] and has tlast on its final beat, which is the framing the parser requires. Also tracks MoldUDP64 sequence numbers and reports gaps and framing errors.

---
 rtl/moldudp64_deframer.sv | 287 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/moldudp64_deframer.sv
// moldudp64_deframer: strips the MoldUDP64 session header and per-message
// length prefixes from a UDP payload stream and re-emits each ITCH message
// as its own AXI-Stream frame. Tracks sequence numbers, gaps and framing errors.

package axi_stream_pkg;
    localparam int AXIS_DATA_WIDTH = 64;
    localparam int AXIS_KEEP_WIDTH = 8;
endpackage

module moldudp64_deframer
    import axi_stream_pkg::*;
#(
    parameter int MAX_MSG_LEN = 50
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                       s_axis_tvalid,
    input  logic                       s_axis_tlast,
    output logic                       s_axis_tready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                       m_axis_tvalid,
    output logic                       m_axis_tlast,
    input  logic                       m_axis_tready,
    output logic [63:0]                cur_seq,
    output logic                       seq_gap,
    output logic                       frame_err,
    output logic [31:0]                pkt_count,
    output logic [63:0]                out_msg_count,
    output logic [31:0]                gap_count,
    output logic [31:0]                err_count
);

    typedef enum logic [1:0] {S_HDR, S_LEN, S_MSG, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  buf_q [16];
    logic [7:0]  buf_d [16];
    logic [4:0]  occ_q, occ_d;
    logic        last_q, last_d;        // tlast byte sits at the buffer tail
    logic        in_rdy_q, in_rdy_d;
    logic [4:0]  hdr_cnt_q, hdr_cnt_d;
    logic [63:0] seq_q, seq_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rem_q, rem_d;
    logic [15:0] msgs_q, msgs_d;
    logic [63:0] exp_q, exp_d;
    logic        seen_q, seen_d;
    logic [63:0] m_data_q, m_data_d;
    logic [7:0]  m_keep_q, m_keep_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic [63:0] cur_seq_q, cur_seq_d;
    logic        gap_q, gap_d;
    logic        err_q, err_d;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic [63:0] msg_cnt_q, msg_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] err_cnt_q, err_cnt_d;

    // Combinational view: buffered bytes followed by the beat accepted this cycle
    logic [7:0]  vbyte [32];
    logic [4:0]  vocc;
    logic        vlast;
    logic        acc;
    logic [3:0]  nin;
    logic        out_free;
    logic [4:0]  pop;
    logic [4:0]  hneed, take;
    logic [3:0]  n, nb;
    logic [15:0] len;
    logic        emit, last_beat;

    // Next-state: one state action per cycle on the merged buffer+input view
    always_comb begin
        int p;
        p         = 0;
        acc       = s_axis_tvalid & in_rdy_q;
        nin       = '0;
        for (int k = 0; k < 8; k++) nin = nin + {3'b0, s_axis_tkeep[k]};
        for (int i = 0; i < 16; i++) vbyte[i] = buf_q[i];
        for (int i = 16; i < 32; i++) vbyte[i] = 8'h00;
        if (acc) begin
            for (int j = 0; j < 8; j++) vbyte[int'(occ_q) + j] = s_axis_tdata[63-8*j -: 8];
        end
        vocc      = occ_q + (acc ? {1'b0, nin} : 5'd0);
        vlast     = last_q | (acc & s_axis_tlast);
        out_free  = ~m_valid_q | m_axis_tready;

        state_d   = state_q;
        hdr_cnt_d = hdr_cnt_q;
        seq_d     = seq_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        msgs_d    = msgs_q;
        exp_d     = exp_q;
        seen_d    = seen_q;
        m_data_d  = m_data_q;
        m_keep_d  = m_keep_q;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        cur_seq_d = cur_seq_q;
        gap_d     = 1'b0;
        err_d     = 1'b0;
        pkt_cnt_d = pkt_cnt_q;
        msg_cnt_d = msg_cnt_q;
        pop       = '0;
        emit      = 1'b0;
        last_beat = 1'b0;
        nb        = '0;
        hneed     = 5'd20 - hdr_cnt_q;
        take      = (vocc < hneed) ? vocc : hneed;
        n         = (rem_q > 16'd8) ? 4'd8 : rem_q[3:0];
        len       = {vbyte[0], vbyte[1]};

        // A completed message leaves the output; a header completion below overrides cur_seq
        if (m_valid_q && m_axis_tready && m_last_q) begin
            msg_cnt_d = msg_cnt_q + 64'd1;
            cur_seq_d = cur_seq_q + 64'd1;
        end

        case (state_q)
            S_HDR: begin
                pop = take;
                for (int i = 0; i < 16; i++) begin
                    if (5'(i) < take) begin
                        p = int'(hdr_cnt_q) + i;
                        if (p >= 10 && p <= 17) seq_d[8*(17-p) +: 8] = vbyte[i];
                        if (p == 18) cnt_d[15:8] = vbyte[i];
                        if (p == 19) cnt_d[7:0]  = vbyte[i];
                    end
                end
                hdr_cnt_d = hdr_cnt_q + take;
                if (hdr_cnt_q + take == 5'd20) begin
                    hdr_cnt_d = '0;
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    gap_d     = seen_q && (seq_d != exp_q);
                    seen_d    = 1'b1;
                    cur_seq_d = seq_d;
                    msgs_d    = cnt_d;
                    if (cnt_d == 16'h0000 || cnt_d == 16'hFFFF) begin
                        exp_d   = seq_d;
                        state_d = S_DROP;
                    end else begin
                        exp_d   = seq_d + {48'd0, cnt_d};
                        state_d = S_LEN;
                    end
                end
            end
            S_LEN: begin
                if (vocc >= 5'd2) begin
                    pop   = 5'd2;
                    rem_d = len;
                    if (len >= 16'd1 && len <= 16'(MAX_MSG_LEN)) begin
                        state_d = S_MSG;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_DROP;
                    end
                end else if (vlast) begin
                    pop = vocc;
                end
            end
            S_MSG: begin
                if (out_free) begin
                    if (vocc >= {1'b0, n}) begin
                        emit      = 1'b1;
                        nb        = n;
                        last_beat = (rem_q <= 16'd8);
                        pop       = {1'b0, n};
                        rem_d     = rem_q - {12'd0, n};
                        if (last_beat) begin
                            msgs_d  = msgs_q - 16'd1;
                            state_d = (msgs_q == 16'd1) ? S_DROP : S_LEN;
                        end
                    end else if (vlast) begin
                        // truncated message: flush what is buffered as a short frame
                        emit      = (vocc != 5'd0);
                        nb        = vocc[3:0];
                        last_beat = 1'b1;
                        pop       = vocc;
                    end
                end
            end
            default: pop = vocc;
        endcase

        // Consuming the tlast byte ends the packet; ending while bytes are still owed is an error
        if (vlast && pop == vocc) begin
            if (state_d == S_LEN || state_d == S_MSG) err_d = 1'b1;
            state_d   = S_HDR;
            hdr_cnt_d = '0;
        end

        if (out_free) begin
            m_valid_d = emit;
            if (emit) begin
                m_data_d = '0;
                m_keep_d = '0;
                m_last_d = last_beat;
                for (int k = 0; k < 8; k++) begin
                    if (4'(k) < nb) begin
                        m_data_d[63-8*k -: 8] = vbyte[k];
                        m_keep_d[7-k]         = 1'b1;
                    end
                end
            end
        end

        for (int i = 0; i < 16; i++) buf_d[i] = vbyte[i + int'(pop)];
        occ_d     = vocc - pop;
        last_d    = vlast && (pop != vocc);
        // input is held off after tlast so the packet boundary stays at the buffer tail
        in_rdy_d  = (occ_d <= 5'd8) && !last_d;
        gap_cnt_d = gap_cnt_q + {31'd0, gap_d};
        err_cnt_d = err_cnt_q + {31'd0, err_d};
    end

    // State, buffer, output and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_HDR;
            buf_q     <= '{default: 8'h00};
            occ_q     <= '0;
            last_q    <= 1'b0;
            in_rdy_q  <= 1'b0;
            hdr_cnt_q <= '0;
            seq_q     <= '0;
            cnt_q     <= '0;
            rem_q     <= '0;
            msgs_q    <= '0;
            exp_q     <= '0;
            seen_q    <= 1'b0;
            m_data_q  <= '0;
            m_keep_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            cur_seq_q <= '0;
            gap_q     <= 1'b0;
            err_q     <= 1'b0;
            pkt_cnt_q <= '0;
            msg_cnt_q <= '0;
            gap_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            occ_q     <= occ_d;
            last_q    <= last_d;
            in_rdy_q  <= in_rdy_d;
            hdr_cnt_q <= hdr_cnt_d;
            seq_q     <= seq_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            msgs_q    <= msgs_d;
            exp_q     <= exp_d;
            seen_q    <= seen_d;
            m_data_q  <= m_data_d;
            m_keep_q  <= m_keep_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            cur_seq_q <= cur_seq_d;
            gap_q     <= gap_d;
            err_q     <= err_d;
            pkt_cnt_q <= pkt_cnt_d;
            msg_cnt_q <= msg_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign s_axis_tready = in_rdy_q;
    assign m_axis_tdata  = m_data_q;
    assign m_axis_tkeep  = m_keep_q;
    assign m_axis_tvalid = m_valid_q;
    assign m_axis_tlast  = m_last_q;
    assign cur_seq       = cur_seq_q;
    assign seq_gap       = gap_q;
    assign frame_err     = err_q;
    assign pkt_count     = pkt_cnt_q;
    assign out_msg_count = msg_cnt_q;
    assign gap_count     = gap_cnt_q;
    assign err_count     = err_cnt_q;

endmodule
